// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner, imem req/ack fetcher and IF/ID register with stall, flush and one-entry skid.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcw_ctrl,
  input  logic        if_id_reg_ctrl,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, pc4_q, pc4_d, skid_q, skid_d, skid_pc4_q, skid_pc4_d;
  logic        valid_q, valid_d;
  logic        hold;
  logic [31:0] tgt, pc_inc;
  assign hold   = ~pcw_ctrl | ~if_id_reg_ctrl;
  assign tgt    = br_target & ~32'h3;
  assign pc_inc = pc_q + 32'd4;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;
    if (state_q == S_BOOT) begin
      state_d = S_FETCH;
    end else if (br_taken) begin
      pc_d    = tgt;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      state_d = (state_q != S_HOLD && !imem_ack) ? S_DRAIN : S_FETCH;
    end else if (state_q == S_FETCH) begin
      if (imem_ack && !hold) begin
        inst_d  = imem_rdata;
        pc4_d   = pc_inc;
        valid_d = 1'b1;
        pc_d    = pc_inc;
      end else if (imem_ack) begin
        skid_d     = imem_rdata;
        skid_pc4_d = pc_inc;
        state_d    = S_HOLD;
      end else if (!hold) begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end else if (state_q == S_HOLD) begin
      if (!hold) begin
        inst_d  = skid_q;
        pc4_d   = skid_pc4_q;
        valid_d = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
    end else if (imem_ack) begin
      state_d = S_FETCH;
    end
    // an outstanding request keeps its stale address until the memory answers it
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inst_q     <= NOP_INST;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      skid_q     <= NOP_INST;
      skid_pc4_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
    end
  end
  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage MIPS-style pipeline; the responder to the ID-stage hazard/branch controls.
- Owns the PC and a request/acknowledge handshake to instruction memory, and loads the IF/ID pipeline register.
- Honours the ID-stage stall controls (pcw_ctrl, if_id_reg_ctrl) and branch redirects.
- Inserts NOP bubbles on flush and on memory wait, and keeps a one-entry skid buffer so an instruction returned during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, instruction word driven into IF/ID on bubble/flush.

Ports:
- clk  input  1  pipeline clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pcw_ctrl  input  1  1 = PC may advance; 0 = hold PC.
- if_id_reg_ctrl  input  1  1 = IF/ID may load; 0 = hold IF/ID.
- br_taken  input  1  branch resolved taken in ID this cycle.
- br_target  input  32  branch target byte address.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; word aligned.
- imem_ack  input  1  fetch data valid this cycle; meaningful only while imem_req=1.
- imem_rdata  input  32  fetched instruction.
- pc  output  32  current fetch PC.
- if_id_inst  output  32  IF/ID instruction register.
- if_id_pc4  output  32  IF/ID PC+4 register.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- hold = ~pcw_ctrl | ~if_id_reg_ctrl.
- br_taken has priority over hold.
- br_target[1:0] is forced to 2'b00.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 gives 0.
- Reset (async assert, sync-to-clk release): pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, skid empty, state=BOOT.
- Handshake: while imem_req=1 and imem_ack=0, imem_addr is held stable. Minimum fetch latency is one cycle (ack in the same cycle as req). Back-to-back fetches are allowed.
- State BOOT: imem_req=0; go to FETCH next cycle.
- State FETCH: imem_req=1, imem_addr=pc. Outcomes on the clock edge:
  - ack & ~hold & ~br_taken: if_id_inst<=imem_rdata, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4, imem_addr<=pc+4; stay in FETCH.
  - ack & hold & ~br_taken: skid<=imem_rdata, skid_pc4<=pc+4; IF/ID unchanged; go to HOLD.
  - ~ack & ~hold: IF/ID <= NOP_INST with valid 0 (bubble); stay in FETCH.
  - ~ack & hold: nothing changes.
- State HOLD: imem_req=0. When ~hold: IF/ID <= skid/skid_pc4 with valid 1, pc<=pc+4, imem_addr<=pc+4, skid emptied; go to FETCH. While hold persists: stay in HOLD, no fetch issued.
- br_taken, any state except BOOT:
  - pc<=br_target.
  - IF/ID <= NOP_INST with valid 0 (flush happens even if hold=1).
  - skid emptied.
  - Next state is DRAIN if in FETCH with imem_ack=0, or if in DRAIN with imem_ack=0. Otherwise go to FETCH with imem_addr<=br_target.
  - Any same-cycle ack data is discarded.
- State DRAIN: imem_req=1 with imem_addr held at the stale address. On ack: discard data, imem_addr<=pc, go to FETCH. A further br_taken while in DRAIN only updates pc.
- br_taken in BOOT is ignored.
- Reset asserted mid-fetch: all state returns immediately to reset values and imem_req drops asynchronously. The memory side must tolerate an abandoned request.
- Latency from redirect to first target instruction in IF/ID: 2 cycles if memory acks with zero wait states.

Test Plan:
- Reset then 4 cycles with imem_ack tied 1 and rdata=addr-derived (32'h0000_0000, 4, 8, ...) -> imem_addr 0,4,8,C on consecutive cycles; if_id_pc4 = 4,8,C; if_id_valid rises in cycle 2.
- pcw_ctrl=0 and if_id_reg_ctrl=0 for 3 cycles while the ack for addr 8 arrives -> IF/ID frozen at inst@4, imem_req=0 during HOLD. On release: IF/ID=inst@8, if_id_pc4=C, next imem_addr=C.
- br_taken=1, br_target=32'h0000_0102 in FETCH with ack=1 -> pc=32'h100, IF/ID=NOP_INST with valid 0, next imem_addr=32'h100, old data discarded.
- br_taken with ack=0 at addr 32'h10, ack arrives 3 cycles later -> imem_addr stays 32'h10 until the ack; data dropped; then imem_addr=target; if_id_valid=0 throughout.
- Memory with 2 wait states, no stalls -> bubble every 3rd cycle: if_id_valid pattern 0,0,1 repeating; pc advances once per ack.
- pc=32'hFFFF_FFFC fetch acked -> pc=0, if_id_pc4=0. Assert rst_n=0 mid-DRAIN -> imem_req=0 and pc=RESET_PC without waiting for a clock edge.
